// File: rtl/sensor_debouncer_if.sv
// Sensor-side bundle for sensor_debouncer: raw BTN1/BTN2 in, clean levels,
// edge strobes and the 2-bit PAIR code out.
interface sensor_debouncer_if;
  logic       BTN1;
  logic       BTN2;
  logic       BTN1_DB;
  logic       BTN2_DB;
  logic       BTN1_RISE;
  logic       BTN1_FALL;
  logic       BTN2_RISE;
  logic       BTN2_FALL;
  logic [1:0] PAIR;
  logic       CHG;

  modport master (
    output BTN1, BTN2,
    input  BTN1_DB, BTN2_DB, BTN1_RISE, BTN1_FALL, BTN2_RISE, BTN2_FALL, PAIR, CHG
  );

  modport slave (
    input  BTN1, BTN2,
    output BTN1_DB, BTN2_DB, BTN1_RISE, BTN1_FALL, BTN2_RISE, BTN2_FALL, PAIR, CHG
  );
endinterface

// File: rtl/sensor_debouncer.sv
// Dual-channel synchroniser + debouncer feeding the entry/exit sequence FSM
// with bounce-free levels, single-cycle edge strobes and a PAIR-change strobe.
module sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic               CLK,
  input  logic               RST,
  sensor_debouncer_if.slave  bus
);

  localparam int unsigned      NCH      = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s;
  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CNT_W-1:0] r_cnt       [NCH];
  logic [CNT_W-1:0] w_cnt_nxt   [NCH];
  logic [NCH-1:0]   r_db;
  logic [NCH-1:0]   r_rise;
  logic [NCH-1:0]   r_fall;
  logic             r_chg;
  logic [NCH-1:0]   w_db_nxt;
  logic [NCH-1:0]   w_rise_nxt;
  logic [NCH-1:0]   w_fall_nxt;
  logic             w_chg_nxt;

  assign w_raw = {bus.BTN2, bus.BTN1};

  // State register: synchronisers, FSM state, counters and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1   <= '0;
      r_s    <= '0;
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= IDLE_LO;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_s1   <= w_raw;
      r_s    <= r_s1;
      r_db   <= w_db_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_chg  <= w_chg_nxt;
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state: any return to the old level inside the window restarts from zero
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        IDLE_LO: begin
          if (r_s[i]) begin
            w_state_nxt[i] = CHK_HI;
            w_cnt_nxt[i]   = CNT_W'(1);
          end else begin
            w_cnt_nxt[i] = '0;
          end
        end
        CHK_HI: begin
          if (!r_s[i]) begin
            w_state_nxt[i] = IDLE_LO;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = IDLE_HI;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!r_s[i]) begin
            w_state_nxt[i] = CHK_LO;
            w_cnt_nxt[i]   = CNT_W'(1);
          end else begin
            w_cnt_nxt[i] = '0;
          end
        end
        CHK_LO: begin
          if (r_s[i]) begin
            w_state_nxt[i] = IDLE_HI;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = IDLE_LO;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = IDLE_LO;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Output decode: level and strobe update only on an accepted window
  always_comb begin
    w_db_nxt   = r_db;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_state[i] == CHK_HI && r_s[i] && r_cnt[i] == CNT_LAST) begin
        w_db_nxt[i]   = 1'b1;
        w_rise_nxt[i] = 1'b1;
      end
      if (r_state[i] == CHK_LO && !r_s[i] && r_cnt[i] == CNT_LAST) begin
        w_db_nxt[i]   = 1'b0;
        w_fall_nxt[i] = 1'b1;
      end
    end
    w_chg_nxt = |{w_rise_nxt, w_fall_nxt};
  end

  assign bus.BTN1_DB   = r_db[0];
  assign bus.BTN2_DB   = r_db[1];
  assign bus.BTN1_RISE = r_rise[0];
  assign bus.BTN1_FALL = r_fall[0];
  assign bus.BTN2_RISE = r_rise[1];
  assign bus.BTN2_FALL = r_fall[1];
  assign bus.PAIR      = r_db;
  assign bus.CHG       = r_chg;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Directed self-checking bench for sensor_debouncer with DEBOUNCE_CYCLES=4.
module tb_sensor_debouncer;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  sensor_debouncer_if bus ();

  sensor_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {B1_DB, B2_DB, B1_RISE, B1_FALL, B2_RISE, B2_FALL, PAIR[1:0], CHG}
  function automatic logic [8:0] outv();
    return {bus.BTN1_DB, bus.BTN2_DB, bus.BTN1_RISE, bus.BTN1_FALL,
            bus.BTN2_RISE, bus.BTN2_FALL, bus.PAIR, bus.CHG};
  endfunction

  function automatic logic [8:0] mk(input logic b1db, input logic b2db,
                                    input logic r1, input logic f1,
                                    input logic r2, input logic f2,
                                    input logic chg);
    return {b1db, b2db, r1, f1, r2, f2, b2db, b1db, chg};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle_low();
    bus.BTN1 = 1'b0;
    bus.BTN2 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    logic [8:0] got;
    bus.BTN1 = 1'b0;
    bus.BTN2 = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    got = outv();
    total++;
    if (got !== 9'b0) begin
      bad++;
      $display("FAIL reset_async: got %b expected %b", got, 9'b0);
    end
    tick();
    RST = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      got = outv();
      total++;
      if (got !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", n, got, 9'b0);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [8:0] got;
    logic [8:0] exp;
    bus.BTN1 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      got = outv();
      exp = mk(n >= 6, 1'b0, n == 6, 1'b0, 1'b0, 1'b0, n == 6);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clean_rise cycle %0d: got %b expected %b", n, got, exp);
      end
    end
    bus.BTN1 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      got = outv();
      exp = mk(n < 6, 1'b0, 1'b0, n == 6, 1'b0, 1'b0, n == 6);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clean_fall cycle %0d: got %b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    int rise_cnt;
    int rise_at;
    int other;
    rise_cnt = 0;
    rise_at  = -1;
    other    = 0;
    for (int t = 1; t <= 24; t++) begin
      bus.BTN2 = (t <= 3) || (t >= 7 && t <= 9) || (t >= 13);
      tick();
      if (bus.BTN2_RISE === 1'b1) begin
        rise_cnt++;
        rise_at = t;
      end
      if (bus.BTN2_FALL !== 1'b0 || bus.BTN1_RISE !== 1'b0 || bus.BTN1_FALL !== 1'b0) other++;
    end
    total++;
    if (rise_cnt != 1) begin
      bad++;
      $display("FAIL bounce_rise_count: got %0d expected %0d", rise_cnt, 1);
    end
    total++;
    if (rise_at != 18) begin
      bad++;
      $display("FAIL bounce_rise_cycle: got %0d expected %0d", rise_at, 18);
    end
    total++;
    if (other != 0) begin
      bad++;
      $display("FAIL bounce_stray_strobes: got %0d expected %0d", other, 0);
    end
    // 3-cycle glitches: BTN2 low while accepted high, BTN1 high while low
    rise_cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      bus.BTN2 = !(t <= 3);
      bus.BTN1 = (t >= 5 && t <= 7);
      tick();
      if ({bus.BTN1_RISE, bus.BTN1_FALL, bus.BTN2_RISE, bus.BTN2_FALL, bus.CHG} !== 5'b0)
        rise_cnt++;
    end
    total++;
    if (rise_cnt != 0) begin
      bad++;
      $display("FAIL glitch_filtered: got %0d strobe cycles expected %0d", rise_cnt, 0);
    end
    total++;
    if (bus.PAIR !== 2'b10) begin
      bad++;
      $display("FAIL glitch_pair: got %b expected %b", bus.PAIR, 2'b10);
    end
  endtask

  task automatic test_entry();
    logic [1:0] codes [5];
    logic [1:0] prv;
    logic [1:0] nxt;
    logic [1:0] cur;
    logic [8:0] got;
    logic [8:0] exp;
    int         chg_cnt;
    int         s;
    int         n;
    codes   = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    chg_cnt = 0;
    settle_low();
    for (int t = 1; t <= 40; t++) begin
      s   = (t - 1) / 10;
      n   = (t - 1) % 10 + 1;
      prv = codes[s];
      nxt = codes[s + 1];
      bus.BTN1 = nxt[0];
      bus.BTN2 = nxt[1];
      tick();
      cur = (n >= 6) ? nxt : prv;
      exp = mk(cur[0], cur[1],
               n == 6 && !prv[0] && nxt[0], n == 6 && prv[0] && !nxt[0],
               n == 6 && !prv[1] && nxt[1], n == 6 && prv[1] && !nxt[1],
               n == 6);
      got = outv();
      if (bus.CHG === 1'b1) chg_cnt++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL entry_seq cycle %0d: got %b expected %b", t, got, exp);
      end
    end
    total++;
    if (chg_cnt != 4) begin
      bad++;
      $display("FAIL entry_chg_count: got %0d expected %0d", chg_cnt, 4);
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] got;
    logic [8:0] exp;
    int         chg_cnt;
    chg_cnt = 0;
    settle_low();
    bus.BTN1 = 1'b1;
    bus.BTN2 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      got = outv();
      exp = mk(n >= 6, n >= 6, n == 6, 1'b0, n == 6, 1'b0, n == 6);
      if (bus.CHG === 1'b1) chg_cnt++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL simul_rise cycle %0d: got %b expected %b", n, got, exp);
      end
    end
    total++;
    if (chg_cnt != 1) begin
      bad++;
      $display("FAIL simul_chg_count: got %0d expected %0d", chg_cnt, 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    logic [8:0] exp;
    settle_low();
    bus.BTN2 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.BTN1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.BTN2 = 1'b0;
    RST = 1'b0;
    #1;
    got = outv();
    total++;
    if (got !== 9'b0) begin
      bad++;
      $display("FAIL reset_mid_async: got %b expected %b", got, 9'b0);
    end
    tick();
    tick();
    total++;
    if (bus.BTN1_DB !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_hold: got %b expected %b", bus.BTN1_DB, 1'b0);
    end
    RST = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      got = outv();
      exp = mk(n >= 6, 1'b0, n == 6, 1'b0, 1'b0, 1'b0, n == 6);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", n, got, exp);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    RST      = 1'b1;
    bus.BTN1 = 1'b0;
    bus.BTN2 = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_entry();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
